// File: rtl/game_sequencer_pkg.sv
// Shared types and default constants for the game sequencer slice.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV        = 500000;
  localparam int DEF_DEBOUNCE_TICKS  = 4;
  localparam int DEF_OVER_HOLD_TICKS = 100;
  localparam int DEF_SCORELEN        = 10;
  localparam int DEF_SPEED_STEP      = 100;
  localparam int DEF_MAX_LEVEL       = 7;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_sequencer_jump_debounce.sv
// Jump button conditioning: synchronizer, tick-rate debounce, rising-edge event.
module jump_debounce
  import game_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic sample,
  input  logic jump_in,
  output logic jev
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [CW-1:0] run_cnt;
  logic          accept;

  // The last of a full run of disagreeing samples flips the debounced level.
  assign accept = sample && (sync2 != deb) && (run_cnt == CW'(DEBOUNCE_TICKS - 1));

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so both flops update from pre-edge values.
      sync1 <= jump_in;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples; accept the level and flag a rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
      deb     <= 1'b0;
      jev     <= 1'b0;
    end else begin
      jev <= accept && sync2;
      if (sample) begin
        if (sync2 == deb || accept) run_cnt <= '0;
        else                        run_cnt <= run_cnt + 1'b1;
        if (accept) deb <= sync2;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: prescaler, game FSM, game-over hold and speed level.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int TICK_DIV        = DEF_TICK_DIV,
  parameter int DEBOUNCE_TICKS  = DEF_DEBOUNCE_TICKS,
  parameter int OVER_HOLD_TICKS = DEF_OVER_HOLD_TICKS,
  parameter int SCORELEN        = DEF_SCORELEN,
  parameter int SPEED_STEP      = DEF_SPEED_STEP,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jump_in,
  input  logic                collide,
  input  logic [SCORELEN-1:0] score,
  output logic                tick,
  output logic                clear,
  output logic                pause,
  output logic                jump_req,
  output logic [2:0]          level,
  output logic [1:0]          state
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam int HW = cnt_width(OVER_HOLD_TICKS + 1);

  state_t              st;
  state_t              nxt;
  logic [PW-1:0]       pre_cnt;
  logic                base;
  logic [HW-1:0]       hold_cnt;
  logic                hold_done;
  logic                jev;
  logic [SCORELEN:0]   thr;
  logic [SCORELEN+1:0] thr_sum;
  logic [SCORELEN:0]   thr_step;
  logic                step_en;
  logic                tick_d;
  logic                clear_d;
  logic                pause_d;
  logic                jump_req_d;

  assign state     = st;
  assign base      = (pre_cnt == PW'(TICK_DIV - 1));
  assign hold_done = (hold_cnt == HW'(OVER_HOLD_TICKS));

  jump_debounce #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .sample (base),
    .jump_in(jump_in),
    .jev    (jev)
  );

  // Free-running prescaler, re-phased on entry to START.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                pre_cnt <= '0;
    else if (nxt == ST_START)  pre_cnt <= '0;
    else if (base)             pre_cnt <= '0;
    else                       pre_cnt <= pre_cnt + 1'b1;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= ST_IDLE;
    else        st <= nxt;
  end

  // Next-state decode; jev outside IDLE or an expired hold is simply dropped.
  always_comb begin
    // NOTE: default first so every path assigns nxt and no latch is inferred.
    nxt = st;
    case (st)
      ST_IDLE:  if (jev)              nxt = ST_START;
      ST_START:                       nxt = ST_RUN;
      ST_RUN:   if (collide)          nxt = ST_OVER;
      ST_OVER:  if (hold_done && jev) nxt = ST_START;
      default:                        nxt = ST_IDLE;
    endcase
  end

  // Hold counter: base pulses spent in OVER, saturating at the hold length.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     hold_cnt <= '0;
    else if (st != ST_OVER)         hold_cnt <= '0;
    else if (base && !hold_done)    hold_cnt <= hold_cnt + 1'b1;
  end

  // Next threshold saturates at all-ones instead of wrapping.
  assign thr_sum  = {1'b0, thr} + (SCORELEN + 2)'(SPEED_STEP);
  assign thr_step = thr_sum[SCORELEN+1] ? '1 : thr_sum[SCORELEN:0];
  assign step_en  = (st == ST_RUN) && ({1'b0, score} >= thr) && (level < 3'(MAX_LEVEL));

  // Speed level: restart at 0 on START, at most one step per cycle in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level <= 3'd0;
      thr   <= (SCORELEN + 1)'(SPEED_STEP);
    end else if (nxt == ST_START) begin
      level <= 3'd0;
      thr   <= (SCORELEN + 1)'(SPEED_STEP);
    end else if (step_en) begin
      level <= level + 3'd1;
      thr   <= thr_step;
    end
  end

  // Output decode from the upcoming state so the strobes line up with it.
  always_comb begin
    tick_d     = base && (nxt == ST_RUN);
    clear_d    = (nxt == ST_START);
    pause_d    = (nxt != ST_RUN);
    jump_req_d = (st == ST_RUN) && jev && !collide;
  end

  // Output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick     <= 1'b0;
      clear    <= 1'b0;
      pause    <= 1'b1;
      jump_req <= 1'b0;
    end else begin
      tick     <= tick_d;
      clear    <= clear_d;
      pause    <= pause_d;
      jump_req <= jump_req_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a behavioural reference model.
module tb_game_sequencer;
  import game_sequencer_pkg::*;

  localparam int TD  = 4;
  localparam int DT  = 2;
  localparam int OHT = 3;
  localparam int SL  = 10;
  localparam int SS  = 5;
  localparam int ML  = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          jump_in = 1'b0;
  logic          collide = 1'b0;
  logic [SL-1:0] score = '0;
  logic          tick, clear, pause, jump_req;
  logic [2:0]    level;
  logic [1:0]    state;

  game_sequencer #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DT), .OVER_HOLD_TICKS(OHT),
    .SCORELEN(SL), .SPEED_STEP(SS), .MAX_LEVEL(ML)
  ) dut (
    .clock(clock), .reset(reset), .jump_in(jump_in), .collide(collide),
    .score(score), .tick(tick), .clear(clear), .pause(pause),
    .jump_req(jump_req), .level(level), .state(state)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in cycles; the tick phase is the distance from the last
  // START (or reset). The debouncer is a window of the last DT samples.
  int m_cyc, m_origin, m_state, m_hold, m_level, m_drops;
  bit m_jev, m_deb;
  bit m_tick, m_clear, m_pause, m_jreq;
  bit jq[$];
  bit hist[$];

  task automatic model_reset();
    m_cyc = 0; m_origin = 0; m_state = 0; m_hold = 0; m_level = 0;
    m_jev = 0; m_deb = 0;
    m_tick = 0; m_clear = 0; m_pause = 1; m_jreq = 0;
    jq = '{1'b0, 1'b0};
    hist.delete();
  endtask

  task automatic model_step(input bit j, input bit c, input int sc);
    bit base;
    bit synced;
    bit new_jev;
    bit same;
    int nxt;
    base    = ((m_cyc - m_origin) % TD) == TD - 1;
    synced  = jq[0];
    new_jev = 0;
    nxt     = m_state;
    case (m_state)
      0: if (m_jev) nxt = 1;
      1: nxt = 2;
      2: if (c) nxt = 3;
      default: if (m_hold >= OHT && m_jev) nxt = 1;
    endcase
    if (m_state == 3 && m_jev && m_hold < OHT) m_drops++;
    m_tick  = base && nxt == 2;
    m_clear = nxt == 1;
    m_pause = nxt != 2;
    m_jreq  = m_state == 2 && m_jev && !c;
    if (nxt == 1) m_level = 0;
    else if (m_state == 2 && sc >= (m_level + 1) * SS && m_level < ML) m_level++;
    if (m_state != 3) m_hold = 0;
    else if (base && m_hold < OHT) m_hold++;
    if (base) begin
      hist.push_back(synced);
      if (hist.size() > DT) void'(hist.pop_front());
      same = 1;
      foreach (hist[i]) if (hist[i] != synced) same = 0;
      if (hist.size() == DT && same && synced != m_deb) begin
        m_deb   = synced;
        new_jev = synced;
      end
    end
    jq.push_back(j);
    void'(jq.pop_front());
    m_jev = new_jev;
    if (nxt == 1) m_origin = m_cyc + 1;
    m_cyc++;
    m_state = nxt;
  endtask

  // ---------------- cycle driver with event bookkeeping ----------------
  int bench_cyc = 0;
  int n_clear, n_tick, n_jreq;
  int clear_cyc, tick1_cyc, tick2_cyc;

  task automatic clear_counts();
    n_clear = 0; n_tick = 0; n_jreq = 0;
    clear_cyc = -1; tick1_cyc = -1; tick2_cyc = -1;
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step(jump_in, collide, int'(score));
    #1;
    bench_cyc++;
    check("state", state, m_state);
    check("tick", tick, m_tick);
    check("clear", clear, m_clear);
    check("pause", pause, m_pause);
    check("jump_req", jump_req, m_jreq);
    check("level", level, m_level);
    if (clear === 1'b1) begin
      n_clear++;
      if (clear_cyc < 0) clear_cyc = bench_cyc;
    end
    if (tick === 1'b1) begin
      n_tick++;
      if (tick1_cyc < 0) tick1_cyc = bench_cyc;
      else if (tick2_cyc < 0) tick2_cyc = bench_cyc;
    end
    if (jump_req === 1'b1) n_jreq++;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Press, expect exactly one restart into RUN at level 0, then release.
  task automatic restart(input string tag);
    clear_counts();
    jump_in = 1'b1;
    run(20);
    check({tag, "_clears"}, n_clear, 1);
    check({tag, "_state"}, state, 2);
    check({tag, "_level"}, level, 0);
    jump_in = 1'b0;
    run(20);
  endtask

  typedef struct {
    int score;
    int exp_level;
  } lvl_vec_t;

  lvl_vec_t lvl_tab[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int hold_left;
    lvl_tab = '{'{0, 0}, '{4, 0}, '{5, 1}, '{9, 1},
                '{10, 2}, '{15, 3}, '{20, 3}, '{30, 3}};
    model_reset();
    clear_counts();
    m_drops = 0;

    // Reset values while reset is held.
    repeat (2) @(negedge clock);
    #1;
    check("rst_state", state, 0);
    check("rst_pause", pause, 1);
    check("rst_tick", tick, 0);
    check("rst_clear", clear, 0);
    check("rst_jreq", jump_req, 0);
    check("rst_level", level, 0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Idle with no button activity.
    run(40);
    check("idle_state", state, 0);
    check("idle_pause", pause, 1);
    check("idle_clears", n_clear, 0);
    check("idle_jreqs", n_jreq, 0);
    check("idle_ticks", n_tick, 0);

    // Hold jump from IDLE: one clear, RUN, tick cadence of TD.
    clear_counts();
    jump_in = 1'b1;
    run(24);
    check("start_clears", n_clear, 1);
    check("start_state", state, 2);
    check("start_pause", pause, 0);
    check("first_tick_gap", tick1_cyc - clear_cyc, TD);
    check("second_tick_gap", tick2_cyc - tick1_cyc, TD);
    jump_in = 1'b0;
    run(16);
    check("start_jreqs", n_jreq, 0);

    // Short pulse rejected, long press accepted, glitch rejected.
    clear_counts();
    jump_in = 1'b1; run(TD); jump_in = 1'b0; run(20);
    check("short_jreqs", n_jreq, 0);
    clear_counts();
    jump_in = 1'b1; run(3 * TD); jump_in = 1'b0; run(20);
    check("long_jreqs", n_jreq, 1);
    clear_counts();
    jump_in = 1'b1; run(1); jump_in = 1'b0; run(20);
    check("glitch_jreqs", n_jreq, 0);
    check("press_state", state, 2);

    // Speed level table.
    foreach (lvl_tab[i]) begin
      score = SL'(lvl_tab[i].score);
      run(3);
      check($sformatf("level_at_%0d", lvl_tab[i].score), level, lvl_tab[i].exp_level);
    end

    // Collide in the same cycle as jev.
    clear_counts();
    jump_in = 1'b1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      collide = m_jev;
      hit = collide;
      cycle();
    end
    collide = 1'b0;
    check("collide_jev_seen", hit, 1);
    check("collide_state", state, 3);
    check("collide_jreqs", n_jreq, 0);
    clear_counts();
    run(20);
    check("over_ticks", n_tick, 0);
    check("over_level_held", level, ML);
    jump_in = 1'b0;
    score = '0;
    run(20);
    restart("restart1");

    // Jump whose rise lands inside the game-over hold is discarded.
    jump_in = 1'b1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cycle();
      hit = (hist.size() > 0) && hist[hist.size() - 1] && !m_deb;
    end
    collide = 1'b1; run(1); collide = 1'b0;
    clear_counts();
    run(30);
    check("hold_state", state, 3);
    check("hold_clears", n_clear, 0);
    check("hold_jev_dropped", m_drops > 0, 1);
    jump_in = 1'b0;
    run(20);
    restart("restart2");

    // Asynchronous reset in mid-RUN.
    score = SL'(10);
    run(5);
    check("pre_reset_level", level, 2);
    reset = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_pause", pause, 1);
    check("mid_rst_level", level, 0);
    check("mid_rst_tick", tick, 0);
    @(negedge clock);
    reset = 1'b1;
    score = '0;
    model_reset();
    run(20);

    // Randomized co-simulation against the model.
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        jump_in   = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 16);
      end
      hold_left--;
      collide = ($urandom_range(0, 39) == 0);
      if (m_clear) score = '0;
      else if (m_state == 2 && $urandom_range(0, 3) == 0 && score < SL'(1000))
        score = score + SL'($urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central controller for the dinosaur game. Owns the game state machine (idle, start, run, game over) and debounces the jump button. Generates the single-cycle game-tick enable and pause/clear strobes that sequence the player, enemy, score and collision datapaths, and derives a speed level from the running score. Sits between the board inputs and every game-logic block, replacing per-block start/stop handling.

## Interface
- TICK_DIV, 500000: clocks per game tick; must be at least 2.
- DEBOUNCE_TICKS, 4: consecutive equal tick-rate samples required to accept a button level.
- OVER_HOLD_TICKS, 100: ticks in game over before a restart is accepted.
- SCORELEN, 10: score width.
- SPEED_STEP, 100: score increment per speed level.
- MAX_LEVEL, 7: saturation level; must be at most 7.
- clock  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- jump_in  in  1  raw, asynchronous jump button; high means pressed.
- collide  in  1  collision flag from the collision block; level-sensitive.
- score  in  SCORELEN  current score.
- tick  out  1  one-cycle game-tick enable; only asserted in RUN.
- clear  out  1  one-cycle strobe that clears player, enemy and score.
- pause  out  1  high whenever state is not RUN.
- jump_req  out  1  one-cycle jump command to the player block.
- level  out  3  speed level, 0..MAX_LEVEL.
- state  out  2  IDLE=0, START=1, RUN=2, OVER=3.

## Operation
- Prescaler: free-running counter 0..TICK_DIV-1 that wraps. The internal base pulse fires when count==TICK_DIV-1. tick = base AND (state==RUN).
- Debounce: jump_in passes through a 2-flop synchronizer. The synced level is sampled only on base pulses. After DEBOUNCE_TICKS consecutive equal samples that differ from the debounced level, the debounced level takes that value. A rising edge of the debounced level produces a one-cycle internal event, jev.
- FSM, IDLE: jev -> START. collide is ignored.
- FSM, START: lasts exactly one cycle, then -> RUN. On entry the prescaler is set to 0, level to 0 and the threshold register to SPEED_STEP. collide is ignored.
- FSM, RUN: collide=1 in any cycle -> OVER. Otherwise jev -> jump_req pulse.
- FSM, OVER: a hold counter counts base pulses up to OVER_HOLD_TICKS. After that, jev -> START. A jev during the hold is discarded, not latched.
- Level: in RUN, if score >= thr and level < MAX_LEVEL, then level+1 and thr += SPEED_STEP, at most one step per cycle. thr is SCORELEN+1 bits and saturates at all-ones, so it never wraps. level holds its value through OVER until the next START.
- Simultaneous collide and jev in RUN: enter OVER, no jump_req.
- Reset mid-operation: the FSM returns to IDLE and all counters and debounce state clear immediately.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, tick=0, clear=0, pause=1, jump_req=0, level=0.
- clear is high in the single cycle with state==START. pause falls in the first RUN cycle.
- First tick after START: exactly TICK_DIV cycles after the START cycle.
- jump_req latency: 2 synchronizer cycles, plus DEBOUNCE_TICKS base samples, plus 1 cycle.
- The transition to OVER is registered one cycle after collide is sampled. pause is high in that same cycle, and no tick occurs in it.
- Level step: one cycle after the score >= thr comparison becomes true.

## Structure
- State encodings and defaults for TICK_DIV, SPEED_STEP and MAX_LEVEL go in define.v, alongside the existing datalen/scorelen constants.
- Sub-module: jump_debounce (synchronizer, sample counter, rising-edge output jev), clocked on clock with the same reset.
- game_sequencer contains the prescaler, FSM, hold counter and level logic.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=2, OVER_HOLD_TICKS=3, SPEED_STEP=5, MAX_LEVEL=3.
- Reset release, then idle for 40 cycles: state=0, pause=1, tick=0, level=0, with no clear or jump_req.
- Hold jump_in high for 20 cycles from IDLE: exactly one clear pulse, then state=2, pause=0. First tick exactly 4 cycles after the clear cycle, then one every 4 cycles. No jump_req.
- In RUN, a jump_in pulse lasting 1 base period is rejected. Holding jump_in for 3 periods gives one jump_req. A 1-cycle glitch on jump_in produces nothing.
- In RUN, step score 0,4,5,9,10,15,20,30: level goes 0,0,1,1,2,3,3,3 (saturated at 3).
- Assert collide in the same cycle as jev: state=3, no jump_req, tick stops. A jump during the first 3 base pulses is ignored. A jump after them gives clear, RUN, level=0.
- Assert reset for 1 cycle in mid-RUN: state=0 and pause=1 immediately, with counters cleared.
